// File: rtl/arbitro_breg.sv
// Round-robin write-port arbiter for the register file, with a bounded burst lock.
// Optional macro ARB_R0_PROTECT_EN: transfers to address 0 complete the handshake but are never written.
module arbitro_breg #(
  parameter int ANCHO_DATO = 32,
  parameter int ANCHO_DIR  = 5,
  parameter int MAX_RAFAGA = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  val0,
  input  logic [ANCHO_DIR-1:0]  dir0,
  input  logic [ANCHO_DATO-1:0] dato0,
  input  logic                  bloq0,
  output logic                  listo0,
  input  logic                  val1,
  input  logic [ANCHO_DIR-1:0]  dir1,
  input  logic [ANCHO_DATO-1:0] dato1,
  input  logic                  bloq1,
  output logic                  listo1,
  output logic [ANCHO_DIR-1:0]  diresc,
  output logic [ANCHO_DATO-1:0] datoesc,
  output logic                  enesc,
  output logic                  propietario,
  output logic                  bloqueado
);

  localparam int CW = $clog2(MAX_RAFAGA + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_RAFAGA);

  typedef enum logic [1:0] {LIBRE, BLOQ0, BLOQ1} estado_t;

  estado_t               estado;
  logic [CW-1:0]         cnt;
  logic                  ult;
  logic                  liberar;
  logic                  hay;
  logic                  escribir;
  logic [ANCHO_DIR-1:0]  dir_sel;
  logic [ANCHO_DATO-1:0] dato_sel;

  // Grants are combinational; a release cycle in a lock state grants nobody.
  always_comb begin
    listo0  = 1'b0;
    listo1  = 1'b0;
    liberar = 1'b0;
    case (estado)
      LIBRE: begin
        if (val0 && (!val1 || ult)) listo0 = 1'b1;
        else if (val1)              listo1 = 1'b1;
      end
      BLOQ0: begin
        if (bloq0 && (cnt < MAXC)) listo0 = val0;
        else                       liberar = 1'b1;
      end
      BLOQ1: begin
        if (bloq1 && (cnt < MAXC)) listo1 = val1;
        else                       liberar = 1'b1;
      end
      default: ;
    endcase
  end

  assign hay      = listo0 | listo1;
  assign dir_sel  = listo1 ? dir1  : dir0;
  assign dato_sel = listo1 ? dato1 : dato0;

`ifdef ARB_R0_PROTECT_EN
  assign escribir = hay && (dir_sel != '0);
`else
  assign escribir = hay;
`endif

  // Lock counter runs every cycle in a lock state, idle or not, so the cap is in wall-clock cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= LIBRE;
      cnt         <= '0;
      ult         <= 1'b1;
      enesc       <= 1'b0;
      diresc      <= '0;
      datoesc     <= '0;
      propietario <= 1'b0;
      bloqueado   <= 1'b0;
    end else begin
      enesc <= escribir;
      if (escribir) begin
        diresc  <= dir_sel;
        datoesc <= dato_sel;
      end
      if (hay) begin
        propietario <= listo1;
        ult         <= listo1;
      end
      case (estado)
        LIBRE: begin
          if (listo0 && bloq0) begin
            estado    <= BLOQ0;
            cnt       <= CW'(1);
            bloqueado <= 1'b1;
          end else if (listo1 && bloq1) begin
            estado    <= BLOQ1;
            cnt       <= CW'(1);
            bloqueado <= 1'b1;
          end
        end
        BLOQ0, BLOQ1: begin
          if (liberar) begin
            estado    <= LIBRE;
            cnt       <= '0;
            bloqueado <= 1'b0;
            ult       <= (estado == BLOQ1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: estado <= LIBRE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_breg.sv
// Scoreboard bench for arbitro_breg: directed grant checks plus a monitor that matches each enesc strobe.
`timescale 1ns/1ps
module tb_arbitro_breg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        val0 = 1'b0, bloq0 = 1'b0, val1 = 1'b0, bloq1 = 1'b0;
  logic [4:0]  dir0 = '0, dir1 = '0;
  logic [31:0] dato0 = '0, dato1 = '0;
  logic        listo0, listo1, enesc, propietario, bloqueado;
  logic [4:0]  diresc;
  logic [31:0] datoesc;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  typedef struct {
    int          due;
    logic [4:0]  dir;
    logic [31:0] dato;
    logic        own;
  } exp_t;
  exp_t sb[$];

  arbitro_breg #(.ANCHO_DATO(32), .ANCHO_DIR(5), .MAX_RAFAGA(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .val0(val0), .dir0(dir0), .dato0(dato0), .bloq0(bloq0), .listo0(listo0),
    .val1(val1), .dir1(dir1), .dato1(dato1), .bloq1(bloq1), .listo1(listo1),
    .diresc(diresc), .datoesc(datoesc), .enesc(enesc),
    .propietario(propietario), .bloqueado(bloqueado)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: every strobe must match the oldest expected write, due exactly one cycle after its grant.
  always @(negedge clk) begin
    exp_t e;
    logic want;
    if (rst_n) begin
      want = (sb.size() > 0) && (sb[0].due == cycle);
      check_output("enesc", {31'b0, enesc}, {31'b0, want});
      if (want) begin
        e = sb.pop_front();
        if (enesc) begin
          check_output("diresc", {27'b0, diresc}, {27'b0, e.dir});
          check_output("datoesc", datoesc, e.dato);
          check_output("propietario", {31'b0, propietario}, {31'b0, e.own});
        end
      end
    end
  end

  task automatic push_write(input logic [4:0] d, input logic [31:0] x, input logic own);
    exp_t e;
    e.due = cycle + 1; e.dir = d; e.dato = x; e.own = own;
`ifdef ARB_R0_PROTECT_EN
    if (d != 5'd0) sb.push_back(e);
`else
    sb.push_back(e);
`endif
  endtask

  task automatic apply_stimulus(
    input logic iv0, input logic ib0, input logic [4:0] id0, input logic [31:0] ix0,
    input logic iv1, input logic ib1, input logic [4:0] id1, input logic [31:0] ix1,
    input logic el0, input logic el1, input logic eblq);
    @(posedge clk);
    #1;
    val0 = iv0; bloq0 = ib0; dir0 = id0; dato0 = ix0;
    val1 = iv1; bloq1 = ib1; dir1 = id1; dato1 = ix1;
    @(negedge clk);
    check_output("listo0", {31'b0, listo0}, {31'b0, el0});
    check_output("listo1", {31'b0, listo1}, {31'b0, el1});
    check_output("bloqueado", {31'b0, bloqueado}, {31'b0, eblq});
    if (el0) push_write(id0, ix0, 1'b0);
    if (el1) push_write(id1, ix1, 1'b1);
  endtask

  task automatic idle(input logic eblq);
    apply_stimulus(0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0, 0, 0, eblq);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 100us");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset values
    #3;
    check_output("rst_listo0", {31'b0, listo0}, 32'd0);
    check_output("rst_listo1", {31'b0, listo1}, 32'd0);
    check_output("rst_enesc", {31'b0, enesc}, 32'd0);
    check_output("rst_diresc", {27'b0, diresc}, 32'd0);
    check_output("rst_datoesc", datoesc, 32'd0);
    check_output("rst_prop", {31'b0, propietario}, 32'd0);
    check_output("rst_bloq", {31'b0, bloqueado}, 32'd0);
    #9 rst_n = 1'b1;

    // Both valid after reset: requester 0 first, then requester 1
    apply_stimulus(1, 0, 5'd3, 32'h0000_0A0A, 1, 0, 5'd4, 32'h0000_1B1B, 1, 0, 0);
    apply_stimulus(1, 0, 5'd6, 32'h0000_0C0C, 1, 0, 5'd4, 32'h0000_1B1B, 0, 1, 0);

    // Single write from requester 1
    apply_stimulus(0, 0, 5'd0, 32'h0, 1, 0, 5'd5, 32'hDEAD_BEEF, 0, 1, 0);
    idle(0);
    idle(0);

    // Burst cap: one LIBRE grant plus seven locked grants, bubble, then requester 1
    for (int i = 0; i < 8; i++)
      apply_stimulus(1, 1, 5'(i + 8), 32'hB000_0000 + i, 1, 0, 5'd2, 32'h1111_2222, 1, 0, (i != 0));
    apply_stimulus(1, 1, 5'd20, 32'hB000_0020, 1, 0, 5'd2, 32'h1111_2222, 0, 0, 1);
    apply_stimulus(1, 1, 5'd20, 32'hB000_0020, 1, 0, 5'd2, 32'h1111_2222, 0, 1, 0);
    apply_stimulus(1, 0, 5'd21, 32'hB000_0021, 0, 0, 5'd0, 32'h0, 1, 0, 0);

    // Early release after three transfers
    apply_stimulus(1, 1, 5'd11, 32'hE000_0001, 0, 0, 5'd0, 32'h0, 1, 0, 0);
    apply_stimulus(1, 1, 5'd12, 32'hE000_0002, 1, 0, 5'd7, 32'h7777_0000, 1, 0, 1);
    apply_stimulus(1, 1, 5'd13, 32'hE000_0003, 1, 0, 5'd7, 32'h7777_0000, 1, 0, 1);
    apply_stimulus(1, 0, 5'd14, 32'hE000_0004, 1, 0, 5'd7, 32'h7777_0000, 0, 0, 1);
    apply_stimulus(1, 0, 5'd14, 32'hE000_0004, 1, 0, 5'd7, 32'h7777_0000, 0, 1, 0);
    apply_stimulus(1, 0, 5'd14, 32'hE000_0004, 0, 0, 5'd0, 32'h0, 1, 0, 0);

    // Reset in BLOQ1 with a strobe pending
    apply_stimulus(0, 0, 5'd0, 32'h0, 1, 1, 5'd15, 32'hCAFE_0001, 0, 1, 0);
    apply_stimulus(0, 0, 5'd0, 32'h0, 1, 1, 5'd16, 32'hCAFE_0002, 0, 1, 1);
    @(posedge clk);
    #1;
    check_output("prerst_enesc", {31'b0, enesc}, 32'd1);
    sb.delete();
    rst_n = 1'b0;
    val0 = 0; bloq0 = 0; val1 = 0; bloq1 = 0;
    #1;
    check_output("midrst_enesc", {31'b0, enesc}, 32'd0);
    check_output("midrst_bloq", {31'b0, bloqueado}, 32'd0);
    check_output("midrst_prop", {31'b0, propietario}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    apply_stimulus(1, 0, 5'd17, 32'h5A5A_0001, 1, 0, 5'd18, 32'hA5A5_0001, 1, 0, 0);
    apply_stimulus(0, 0, 5'd0, 32'h0, 1, 0, 5'd18, 32'hA5A5_0001, 0, 1, 0);

    // Address 0 write: suppressed only when protection is built in
    apply_stimulus(1, 0, 5'd0, 32'h0BAD_F00D, 0, 0, 5'd0, 32'h0, 1, 0, 0);
    idle(0);
    idle(0);

    check_output("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
